// File: rtl/pdetect_acq_seq_if.sv
// Bundles the phase-detector sample stream and the sequencer's control/status outputs.
// The master side drives the detector samples and enable; the slave side is the sequencer.
interface pdetect_acq_seq_if #(
  parameter int w = 18
);
  logic                enable;
  logic signed [w-1:0] ang_in;
  logic                strobe_in;
  logic [1:0]          gain_sel;
  logic                clear_out;
  logic                locked;
  logic                lost;
  logic [1:0]          state;

  modport master (
    output enable, ang_in, strobe_in,
    input  gain_sel, clear_out, locked, lost, state
  );

  modport slave (
    input  enable, ang_in, strobe_in,
    output gain_sel, clear_out, locked, lost, state
  );
endinterface

// File: rtl/pdetect_acq_seq.sv
// Lock-acquisition sequencer: classifies strobed phase-detector samples and steps the loop
// through FREQ, PHASE and LOCKED, driving gain select, integrator clear and lock status.
module pdetect_acq_seq #(
  parameter int w           = 18,
  parameter int fdwell      = 16,
  parameter int dwell       = 64,
  parameter int lose        = 8,
  parameter int lock_thresh = 4096,
  parameter int cw          = 8
) (
  input  logic             clk,
  input  logic             rst,
  pdetect_acq_seq_if.slave bus
);

  typedef enum logic [1:0] {
    idle_e   = 2'd0,
    freq_e   = 2'd1,
    phase_e  = 2'd2,
    locked_e = 2'd3
  } state_t;

  localparam logic signed [w-1:0] max_c      = {1'b0, {(w-1){1'b1}}};
  localparam logic signed [w-1:0] min_c      = {1'b1, {(w-1){1'b0}}};
  localparam logic [w:0]          thresh_c   = (w+1)'(lock_thresh);
  localparam logic [cw-1:0]       fdwell_c   = cw'(fdwell);
  localparam logic [cw-1:0]       dwell_c    = cw'(dwell);
  localparam logic [cw-1:0]       lose_c     = cw'(lose);
  localparam logic [cw-1:0]       cnt_max_c  = {cw{1'b1}};

  state_t        state_r;
  logic [cw-1:0] cnt_r;
  logic [1:0]    gain_r;
  logic          clear_r;
  logic          locked_r;
  logic          lost_r;

  logic [w:0]    ext_s;
  logic [w:0]    mag_s;
  logic          sat_s;
  logic          in_s;
  logic [cw-1:0] cnt_inc_s;

  // Sample classification; magnitude uses one extra bit so the most negative code cannot overflow.
  always_comb begin
    ext_s     = {bus.ang_in[w-1], bus.ang_in};
    mag_s     = ext_s;
    sat_s     = 1'b0;
    in_s      = 1'b0;
    cnt_inc_s = cnt_r;
    if (ext_s[w]) begin
      mag_s = ~ext_s + {{w{1'b0}}, 1'b1};
    end else begin
      mag_s = ext_s;
    end
    if ((bus.ang_in == max_c) || (bus.ang_in == min_c)) begin
      sat_s = 1'b1;
    end else begin
      sat_s = 1'b0;
    end
    if (!sat_s && (mag_s <= thresh_c)) begin
      in_s = 1'b1;
    end else begin
      in_s = 1'b0;
    end
    if (cnt_r == cnt_max_c) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(cw-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer state, dwell counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      state_r  <= idle_e;
      cnt_r    <= {cw{1'b0}};
      gain_r   <= 2'd0;
      clear_r  <= 1'b0;
      locked_r <= 1'b0;
      lost_r   <= 1'b0;
    end else begin
      clear_r <= 1'b0;
      lost_r  <= 1'b0;
      case (state_r)
        idle_e: begin
          state_r <= freq_e;
          gain_r  <= 2'd3;
          clear_r <= 1'b1;
          cnt_r   <= {cw{1'b0}};
        end
        freq_e: begin
          if (bus.strobe_in) begin
            if (sat_s) begin
              cnt_r <= {cw{1'b0}};
            end else if (cnt_inc_s == fdwell_c) begin
              state_r <= phase_e;
              gain_r  <= 2'd2;
              cnt_r   <= {cw{1'b0}};
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        phase_e: begin
          if (bus.strobe_in) begin
            if (sat_s) begin
              state_r <= freq_e;
              gain_r  <= 2'd3;
              clear_r <= 1'b1;
              cnt_r   <= {cw{1'b0}};
            end else if (!in_s) begin
              cnt_r <= {cw{1'b0}};
            end else if (cnt_inc_s == dwell_c) begin
              state_r  <= locked_e;
              gain_r   <= 2'd1;
              locked_r <= 1'b1;
              cnt_r    <= {cw{1'b0}};
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        locked_e: begin
          // A saturated sample and an exhausted out-of-threshold run exit identically.
          if (bus.strobe_in) begin
            if (sat_s || (!in_s && (cnt_inc_s == lose_c))) begin
              state_r  <= freq_e;
              gain_r   <= 2'd3;
              clear_r  <= 1'b1;
              lost_r   <= 1'b1;
              locked_r <= 1'b0;
              cnt_r    <= {cw{1'b0}};
            end else if (in_s) begin
              cnt_r <= {cw{1'b0}};
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        default: begin
          state_r  <= idle_e;
          gain_r   <= 2'd0;
          locked_r <= 1'b0;
          cnt_r    <= {cw{1'b0}};
        end
      endcase
    end
  end

  assign bus.state     = state_r;
  assign bus.gain_sel  = gain_r;
  assign bus.clear_out = clear_r;
  assign bus.locked    = locked_r;
  assign bus.lost      = lost_r;

endmodule

// File: tb/tb_pdetect_acq_seq.sv
// Directed, table-driven bench for pdetect_acq_seq with hand-computed expectations,
// plus hand-written reset sequences.
module tb_pdetect_acq_seq;

  localparam int W = 18;

  logic clk;
  logic rst;

  pdetect_acq_seq_if #(.w(W)) bus ();

  pdetect_acq_seq #(
    .w(W), .fdwell(16), .dwell(64), .lose(8), .lock_thresh(4096), .cw(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic                en;
    logic                strb;
    logic signed [W-1:0] ang;
    int                  reps;
    logic [1:0]          st;
    logic [1:0]          gs;
    logic                clr;
    logic                lck;
    logic                lst;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input string name, input logic en, input logic strb, input int ang,
                     input int reps, input logic [1:0] st, input logic [1:0] gs,
                     input logic clr, input logic lck, input logic lst);
    vec_t v;
    v.name = name; v.en = en; v.strb = strb; v.ang = W'(ang); v.reps = reps;
    v.st = st; v.gs = gs; v.clr = clr; v.lck = lck; v.lst = lst;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic [1:0] gs,
                       input logic clr, input logic lck, input logic lst);
    n_tests++;
    if (bus.state !== st || bus.gain_sel !== gs || bus.clear_out !== clr ||
        bus.locked !== lck || bus.lost !== lst) begin
      n_fail++;
      $display("FAIL %s: got state=%0d gain=%0d clear=%0b locked=%0b lost=%0b, want state=%0d gain=%0d clear=%0b locked=%0b lost=%0b",
               name, bus.state, bus.gain_sel, bus.clear_out, bus.locked, bus.lost,
               st, gs, clr, lck, lst);
    end
  endtask

  task automatic drive(input logic en, input logic strb, input logic signed [W-1:0] ang, input int reps);
    for (int r = 0; r < reps; r++) begin
      @(negedge clk);
      bus.enable    = en;
      bus.strobe_in = strb;
      bus.ang_in    = ang;
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.strobe_in = 1'b0; bus.ang_in = '0;

    // name, en, strb, ang, reps, state, gain, clear, locked, lost
    add("idle_to_freq",     1'b1, 1'b1, 0,       1,   2'd1, 2'd3, 1'b1, 1'b0, 1'b0);
    add("freq_15",          1'b1, 1'b1, 0,       15,  2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    add("freq_16_phase",    1'b1, 1'b1, 0,       1,   2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("phase_63",         1'b1, 1'b1, 0,       63,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("phase_64_locked",  1'b1, 1'b1, 0,       1,   2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    add("lock_out_7",       1'b1, 1'b1, 5000,    7,   2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    add("lock_in_clears",   1'b1, 1'b1, 0,       1,   2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    add("lock_out_7b",      1'b1, 1'b1, 5000,    7,   2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    add("lock_out_8_lost",  1'b1, 1'b1, 5000,    1,   2'd1, 2'd3, 1'b1, 1'b0, 1'b1);
    add("lost_one_cycle",   1'b1, 1'b1, 0,       1,   2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      add("freq_clean_4",   1'b1, 1'b1, 0,       4,   2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
      add("freq_sat_pos",   1'b1, 1'b1, 131071,  1,   2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    end
    add("freq_clean_15",    1'b1, 1'b1, 0,       15,  2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    add("freq_clean_16",    1'b1, 1'b1, 0,       1,   2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("phase_neg4096_63", 1'b1, 1'b1, -4096,   63,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("phase_neg4097",    1'b1, 1'b1, -4097,   1,   2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("phase_after_clr",  1'b1, 1'b1, 0,       63,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("phase_nostrobe",   1'b1, 1'b0, 131071,  100, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("phase_held_64",    1'b1, 1'b1, 0,       1,   2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    add("lock_sat_neg",     1'b1, 1'b1, -131072, 1,   2'd1, 2'd3, 1'b1, 1'b0, 1'b1);
    add("refreq_16",        1'b1, 1'b1, 0,       16,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("phase_63_again",   1'b1, 1'b1, 0,       63,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("en_drop_on_64th",  1'b0, 1'b1, 0,       1,   2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    add("idle_stays",       1'b0, 1'b1, 0,       3,   2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    add("re_enable",        1'b1, 1'b0, 0,       1,   2'd1, 2'd3, 1'b1, 1'b0, 1'b0);
    add("freq_sparse_16",   1'b1, 1'b1, 0,       16,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    add("to_locked_64",     1'b1, 1'b1, 4096,    64,  2'd3, 2'd1, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_values", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].strb, vecs[i].ang, vecs[i].reps);
      check(vecs[i].name, vecs[i].st, vecs[i].gs, vecs[i].clr, vecs[i].lck, vecs[i].lst);
    end

    // Reset while LOCKED with a saturating strobe pending: no lost pulse, all outputs cleared.
    @(negedge clk);
    rst = 1'b1; bus.enable = 1'b1; bus.strobe_in = 1'b1; bus.ang_in = 18'sd131071;
    @(posedge clk);
    #1;
    check("rst_in_locked", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; bus.strobe_in = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge_after_rst", 2'd1, 2'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1);
    check("clear_one_cycle", 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pdetect_acq_seq.md
# pdetect_acq_seq

Lock-acquisition sequencer for the phase-detector path. It watches the saturating phase-detector output and its strobe and steps the loop through frequency acquisition, phase pull-in and locked tracking. It drives the loop-gain select, a one-cycle integrator clear and the lock/lost status flags. It sits between the phase detector and the loop filter, on the same clock.

## Interface
- w, 18, angle width (two's complement), matches the phase detector width
- fdwell, 16, consecutive unsaturated strobes required to leave FREQ
- dwell, 64, consecutive in-threshold strobes required to enter LOCKED
- lose, 8, consecutive out-of-threshold strobes in LOCKED that declare loss of lock
- lock_thresh, 4096, in-lock magnitude limit, inclusive
- cw, 8, counter width; must hold max(fdwell, dwell, lose)

- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run request; low forces IDLE
- ang_in  in  w  signed phase detector output (ang_out of the detector)
- strobe_in  in  1  valid qualifier for ang_in (strobe_out of the detector)
- gain_sel  out  2  loop gain select: IDLE 0, FREQ 3, PHASE 2, LOCKED 1
- clear_out  out  1  one-cycle integrator clear pulse
- locked  out  1  high while in LOCKED
- lost  out  1  one-cycle pulse on loss of lock
- state  out  2  debug: IDLE 0, FREQ 1, PHASE 2, LOCKED 3

## Operation
- Sample classes, evaluated only on cycles with strobe_in=1:
  - sat: ang_in == 2^(w-1)-1 or ang_in == -2^(w-1).
  - in: not sat and |ang_in| <= lock_thresh. |x| is computed in w+1 bits, so there is no overflow at the most negative value.
  - out: neither sat nor in.
- Single counter cnt, cleared on every state change. It saturates at its target and never wraps.
- IDLE: enable=1 moves to FREQ and pulses clear_out.
- FREQ:
  - sat clears cnt; in or out increments cnt.
  - When cnt reaches fdwell, move to PHASE.
- PHASE:
  - sat moves to FREQ and pulses clear_out.
  - out clears cnt; in increments cnt.
  - When cnt reaches dwell, move to LOCKED.
- LOCKED:
  - sat moves to FREQ and pulses clear_out and lost.
  - out increments cnt; in clears cnt.
  - When cnt reaches lose, move to FREQ and pulse clear_out and lost.
- enable=0 in any state moves to IDLE next cycle and clears cnt. It takes priority over a simultaneous strobe and over any transition.
- Cycles with strobe_in=0 hold cnt and state, except for the enable rule.

## Timing
- All outputs are registered.
- state, gain_sel and locked change on the edge after the strobe that completes a transition. The target count is reached on the fdwell-th, dwell-th or lose-th qualifying strobe.
- clear_out and lost are asserted in the same cycle the new state first appears, for exactly one cycle.
- Reset values: state=IDLE, cnt=0, gain_sel=0, clear_out=0, locked=0, lost=0.
- Reset mid-operation overrides enable and strobe. There is no lost pulse on reset.
- The first IDLE to FREQ step after reset occurs on the first edge with rst=0 and enable=1.
- Back-to-back strobes every cycle are supported, as is a sparse strobe at any rate.

## Test plan
- Reset, enable=1, strobe every cycle, ang_in=0 -> clear_out pulse with state=1 on cycle 1; state=2 after 16 strobes; state=3 and locked=1 after 64 more.
- In FREQ, strobes with ang_in=131071 every 5th sample -> cnt never reaches 16 and state stays 1; then 16 clean samples -> PHASE.
- In LOCKED, ang_in=5000 for 7 strobes, then 0, then 8 strobes -> no exit after 7. After the 8th: state=1, lost and clear_out pulse one cycle, gain_sel=3.
- In LOCKED, a single ang_in=-131072 -> immediate FREQ with lost pulse. ang_in=-4096 in PHASE counts as in; -4097 clears cnt.
- strobe_in=0 for 100 cycles in PHASE with ang_in=131071 -> no state or cnt change.
- enable dropped in the same cycle as the 64th in-strobe -> IDLE (state=0, gain_sel=0, locked=0), no LOCKED. rst during LOCKED -> all outputs at reset values next cycle, lost=0.
